// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for the MAC sequencer: default sizes and FSM state encoding.
package mac_sequencer_pkg;

   localparam int W_DEF = 32;
   localparam int N_DEF = 8;

   typedef enum logic [1:0] {
      ST_MAC   = 2'd0,
      ST_ABS   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_OUT   = 2'd3
   } state_t;

endpackage

// File: rtl/mac_sequencer_if.sv
// Bundle of sample stream, coefficient port, accumulator command/return and result port.
interface mac_sequencer_if import mac_sequencer_pkg::*; #(
   parameter int W = W_DEF,
   parameter int N = N_DEF
);
   localparam int DW = W / 2;
   localparam int AW = $clog2(N);

   logic                 flush;
   logic                 abs_mode;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] in_data;
   logic                 coef_we;
   logic [AW-1:0]        coef_addr;
   logic signed [DW-1:0] coef_data;
   logic                 acc_en;
   logic                 acc_reset;
   logic                 acc_load;
   logic                 acc_abs;
   logic signed [W-1:0]  acc_in;
   logic signed [W-1:0]  acc_out;
   logic                 res_valid;
   logic                 res_ready;
   logic signed [W-1:0]  res_data;

   modport master (
      output flush, abs_mode, in_valid, in_data, coef_we, coef_addr, coef_data,
             acc_out, res_ready,
      input  in_ready, acc_en, acc_reset, acc_load, acc_abs, acc_in,
             res_valid, res_data
   );

   modport slave (
      input  flush, abs_mode, in_valid, in_data, coef_we, coef_addr, coef_data,
             acc_out, res_ready,
      output in_ready, acc_en, acc_reset, acc_load, acc_abs, acc_in,
             res_valid, res_data
   );

endinterface

// File: rtl/mac_sequencer_coef_bank.sv
// N x DW signed coefficient register file: synchronous write, asynchronous read,
// synchronous active-low clear. A read in the write cycle still sees the old value.
module mac_sequencer_coef_bank import mac_sequencer_pkg::*; #(
   parameter int DW = W_DEF / 2,
   parameter int N  = N_DEF,
   parameter int AW = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 we,
   input  logic [AW-1:0]        waddr,
   input  logic signed [DW-1:0] wdata,
   input  logic [AW-1:0]        raddr,
   output logic signed [DW-1:0] rdata
);

   logic signed [DW-1:0] mem [N];

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mac_sequencer.sv
// Frame sequencer feeding an external accumulator: one product per accepted sample,
// optional magnitude step, then captures the accumulator output as the frame result.
module mac_sequencer import mac_sequencer_pkg::*; #(
   parameter int W = W_DEF,
   parameter int N = N_DEF
) (
   input  logic           clk,
   input  logic           reset,
   mac_sequencer_if.slave bus
);

   localparam int            DW   = W / 2;
   localparam int            AW   = $clog2(N);
   localparam logic [AW-1:0] LAST = AW'(N - 1);

   function automatic logic signed [W-1:0] sext(input logic signed [DW-1:0] v);
      return {{(W - DW){v[DW-1]}}, v};
   endfunction

   state_t               state, state_nx;
   logic [AW-1:0]        idx, idx_nx;
   logic                 drain, drain_nx;
   logic                 abs_r, abs_nx;
   logic                 ready_c;
   logic signed [DW-1:0] coef_rd;
   logic signed [W-1:0]  product_p0;

   logic                 acc_en_p1, acc_en_nx;
   logic                 acc_reset_p1, acc_reset_nx;
   logic                 acc_load_p1, acc_load_nx;
   logic                 acc_abs_p1, acc_abs_nx;
   logic signed [W-1:0]  acc_in_p1, acc_in_nx;
   logic                 res_valid, res_valid_nx;
   logic signed [W-1:0]  res_data, res_data_nx;

   mac_sequencer_coef_bank #(.DW(DW), .N(N), .AW(AW)) u_coef (
      .clk   (clk),
      .reset (reset),
      .we    (bus.coef_we),
      .waddr (bus.coef_addr),
      .wdata (bus.coef_data),
      .raddr (idx),
      .rdata (coef_rd)
   );

   // p0: full-width signed product of the presented sample and the current tap
   assign product_p0 = sext(bus.in_data) * sext(coef_rd);

   always_comb begin
      state_nx     = state;
      idx_nx       = idx;
      drain_nx     = drain;
      abs_nx       = abs_r;
      ready_c      = 1'b0;
      acc_en_nx    = 1'b0;
      acc_reset_nx = 1'b0;
      acc_load_nx  = 1'b0;
      acc_abs_nx   = 1'b0;
      acc_in_nx    = acc_in_p1;
      res_valid_nx = res_valid;
      res_data_nx  = res_data;
      if (bus.flush) begin
         state_nx     = ST_MAC;
         idx_nx       = '0;
         drain_nx     = 1'b0;
         acc_en_nx    = 1'b1;
         acc_reset_nx = 1'b1;
         res_valid_nx = 1'b0;
      end else begin
         case (state)
            ST_MAC: begin
               ready_c = 1'b1;
               if (bus.in_valid) begin
                  acc_en_nx   = 1'b1;
                  acc_in_nx   = product_p0;
                  acc_load_nx = (idx == '0);
                  if (idx == '0) abs_nx = bus.abs_mode;
                  if (idx == LAST) begin
                     idx_nx   = '0;
                     drain_nx = 1'b0;
                     state_nx = abs_r ? ST_ABS : ST_DRAIN;
                  end else begin
                     idx_nx = idx + AW'(1);
                  end
               end
            end
            ST_ABS: begin
               acc_en_nx  = 1'b1;
               acc_abs_nx = 1'b1;
               acc_in_nx  = '0;
               drain_nx   = 1'b0;
               state_nx   = ST_DRAIN;
            end
            ST_DRAIN: begin
               // second drain cycle: the last command has reached the accumulator register
               if (drain) begin
                  drain_nx     = 1'b0;
                  res_data_nx  = bus.acc_out;
                  res_valid_nx = 1'b1;
                  state_nx     = ST_OUT;
               end else begin
                  drain_nx = 1'b1;
               end
            end
            ST_OUT: begin
               if (bus.res_ready) begin
                  res_valid_nx = 1'b0;
                  state_nx     = ST_MAC;
               end
            end
            default: state_nx = ST_MAC;
         endcase
      end
   end

   // p1: command stage registers, plus control state and result capture
   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= ST_MAC;
         idx          <= '0;
         drain        <= 1'b0;
         abs_r        <= 1'b0;
         acc_en_p1    <= 1'b0;
         acc_reset_p1 <= 1'b0;
         acc_load_p1  <= 1'b0;
         acc_abs_p1   <= 1'b0;
         acc_in_p1    <= '0;
         res_valid    <= 1'b0;
         res_data     <= '0;
      end else begin
         state        <= state_nx;
         idx          <= idx_nx;
         drain        <= drain_nx;
         abs_r        <= abs_nx;
         acc_en_p1    <= acc_en_nx;
         acc_reset_p1 <= acc_reset_nx;
         acc_load_p1  <= acc_load_nx;
         acc_abs_p1   <= acc_abs_nx;
         acc_in_p1    <= acc_in_nx;
         res_valid    <= res_valid_nx;
         res_data     <= res_data_nx;
      end
   end

   assign bus.in_ready  = reset & ready_c;
   assign bus.acc_en    = acc_en_p1;
   assign bus.acc_reset = acc_reset_p1;
   assign bus.acc_load  = acc_load_p1;
   assign bus.acc_abs   = acc_abs_p1;
   assign bus.acc_in    = acc_in_p1;
   assign bus.res_valid = res_valid;
   assign bus.res_data  = res_data;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: plays the accumulator, predicts every command and frame
// result from per-sample arithmetic, and runs directed plus randomized frames.
module tb_mac_sequencer;

   localparam int W  = 32;
   localparam int N  = 4;
   localparam int DW = W / 2;
   localparam int AW = $clog2(N);

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mac_sequencer_if #(.W(W), .N(N)) bus ();

   mac_sequencer #(.W(W), .N(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // external accumulator
   logic signed [W-1:0] acc_q = '0;
   always @(posedge clk) begin
      if (bus.acc_en) begin
         if (bus.acc_reset)     acc_q <= '0;
         else if (bus.acc_load) acc_q <= bus.acc_in;
         else if (bus.acc_abs)  acc_q <= (acc_q < 0) ? -acc_q : acc_q;
         else                   acc_q <= acc_q + bus.acc_in;
      end
   end
   assign bus.acc_out = acc_q;

   // reference model state
   int m_coef [N];
   int m_cnt  = 0;
   int m_sum  = 0;
   bit m_abs  = 1'b0;
   bit m_pend = 1'b0;
   int q_data [$];
   bit q_abs  [$];
   int exp_kind = 3;      // what the next edge does: 0 idle, 1 sample, 2 flush, 3 reset
   int exp_in   = 0;
   bit exp_load = 1'b0;
   bit prev_hold = 1'b0;
   int abs_pulses = 0, abs_total = 0, rst_pulses = 0, load_cmds = 0, add_cmds = 0;
   int res_count = 0;
   int last_res  = 0;

   always @(negedge clk) begin
      bit rdy_exp, res_hs;
      int a, c, p;
      case (exp_kind)
         3: begin
            chk("rst_ctl", 32'({bus.acc_en, bus.acc_reset, bus.acc_load, bus.acc_abs, bus.res_valid}), 32'd0);
            chk("rst_acc_in", bus.acc_in, 32'd0);
            chk("rst_res_data", bus.res_data, 32'd0);
         end
         2: begin
            chk("flush_cmd", 32'({bus.acc_en, bus.acc_reset, bus.acc_load, bus.acc_abs}), 32'b1100);
            chk("flush_res_valid", 32'(bus.res_valid), 32'd0);
            rst_pulses++;
         end
         1: begin
            chk("cmd_bits", 32'({bus.acc_en, bus.acc_reset, bus.acc_load, bus.acc_abs}),
                32'({1'b1, 1'b0, exp_load, 1'b0}));
            chk("cmd_in", bus.acc_in, exp_in);
            if (exp_load) load_cmds++; else add_cmds++;
         end
         default: begin
            chk("idle_cmd", 32'({bus.acc_reset, bus.acc_load, bus.acc_en ^ bus.acc_abs}), 32'd0);
            if (bus.acc_en && bus.acc_abs) begin
               chk("abs_cmd_in", bus.acc_in, 32'd0);
               abs_pulses++;
               abs_total++;
            end
         end
      endcase
      if (prev_hold) chk("res_valid_hold", 32'(bus.res_valid), 32'd1);

      rdy_exp = reset && !bus.flush && !m_pend;
      chk("in_ready", 32'(bus.in_ready), 32'(rdy_exp));

      res_hs = bus.res_valid && bus.res_ready && reset && !bus.flush;
      if (bus.res_valid) begin
         if (q_data.size() == 0) chk("res_spurious", 32'd1, 32'd0);
         else                    chk("res_data", bus.res_data, q_data[0]);
      end
      if (res_hs && q_data.size() != 0) begin
         chk("abs_pulse_count", abs_pulses, 32'(q_abs[0]));
         last_res = bus.res_data;
         res_count++;
         void'(q_data.pop_front());
         void'(q_abs.pop_front());
         abs_pulses = 0;
         m_pend = 1'b0;
      end

      if (!reset) begin
         exp_kind = 3;
         for (int i = 0; i < N; i++) m_coef[i] = 0;
         m_cnt = 0; m_pend = 1'b0; abs_pulses = 0;
         q_data.delete(); q_abs.delete();
      end else if (bus.flush) begin
         exp_kind = 2;
         m_cnt = 0; m_pend = 1'b0; abs_pulses = 0;
         q_data.delete(); q_abs.delete();
      end else begin
         if (bus.in_valid && rdy_exp) begin
            a = bus.in_data;
            c = m_coef[m_cnt];
            p = a * c;
            exp_kind = 1;
            exp_in   = p;
            exp_load = (m_cnt == 0);
            if (m_cnt == 0) begin
               m_abs = bus.abs_mode;
               m_sum = p;
            end else begin
               m_sum = m_sum + p;
            end
            m_cnt++;
            if (m_cnt == N) begin
               q_data.push_back(m_abs ? ((m_sum < 0) ? -m_sum : m_sum) : m_sum);
               q_abs.push_back(m_abs);
               m_pend = 1'b1;
               m_cnt  = 0;
            end
         end else begin
            exp_kind = 0;
         end
         if (bus.coef_we) m_coef[bus.coef_addr] = bus.coef_data;
      end
      prev_hold = bus.res_valid && !res_hs && reset && !bus.flush;
   end

   // stimulus
   int vs [N];
   int cs [N];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_coefs();
      for (int i = 0; i < N; i++) begin
         bus.coef_we   = 1'b1;
         bus.coef_addr = AW'(i);
         bus.coef_data = DW'(cs[i]);
         step();
      end
      bus.coef_we = 1'b0;
   endtask

   task automatic send_frame(input int nsamp, input bit absm, input int gap_pct, input bit rnd_coef);
      for (int i = 0; i < nsamp; i++) begin
         int tries = 0;
         bit done  = 1'b0;
         while (!done) begin
            if (int'($urandom_range(99)) < gap_pct) begin
               bus.in_valid = 1'b0;
            end else begin
               bus.in_valid = 1'b1;
               bus.in_data  = DW'(vs[i]);
               bus.abs_mode = absm;
            end
            if (rnd_coef && $urandom_range(9) == 0) begin
               bus.coef_we   = 1'b1;
               bus.coef_addr = AW'($urandom_range(N - 1));
               bus.coef_data = DW'($urandom);
            end else begin
               bus.coef_we = 1'b0;
            end
            @(negedge clk);
            done = bus.in_valid && bus.in_ready;
            step();
            tries++;
            if (!done && tries > 200) begin
               chk("send_timeout", 32'd0, 32'd1);
               bus.in_valid = 1'b0;
               bus.coef_we  = 1'b0;
               return;
            end
         end
      end
      bus.in_valid = 1'b0;
      bus.coef_we  = 1'b0;
   endtask

   task automatic wait_result(input string nm, input int lit, input bit use_lit, input bit rnd_ready);
      int start = res_count;
      int n = 0;
      if (rnd_ready) bus.res_ready = 1'($urandom_range(1));
      while (res_count == start && n < 300) begin
         step();
         if (rnd_ready) bus.res_ready = 1'($urandom_range(1));
         n++;
      end
      if (res_count == start) chk({nm, "_timeout"}, 32'd0, 32'd1);
      else if (use_lit)       chk(nm, last_res, lit);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int l0, a0, x0, r0, n;
      bus.flush = 1'b0; bus.abs_mode = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
      bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0; bus.res_ready = 1'b1;
      reset = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      step();

      cs = '{1, 2, 3, 4};
      set_coefs();

      // 1: plain dot product, one load then adds
      l0 = load_cmds; a0 = add_cmds;
      vs = '{10, 20, 30, 40};
      send_frame(N, 1'b0, 0, 1'b0);
      wait_result("t1_res", 300, 1'b1, 1'b0);
      chk("t1_loads", load_cmds - l0, 32'd1);
      chk("t1_adds", add_cmds - a0, 32'd3);

      // 2: magnitude vs signed result
      x0 = abs_total;
      vs = '{-10, -20, -30, -40};
      send_frame(N, 1'b1, 0, 1'b0);
      wait_result("t2_abs_res", 300, 1'b1, 1'b0);
      chk("t2_abs_pulses", abs_total - x0, 32'd1);
      x0 = abs_total;
      send_frame(N, 1'b0, 0, 1'b0);
      wait_result("t2_neg_res", 32'hFFFFFED4, 1'b1, 1'b0);
      chk("t2_no_abs", abs_total - x0, 32'd0);

      // 3: result held under back-pressure
      bus.res_ready = 1'b0;
      vs = '{10, 20, 30, 40};
      send_frame(N, 1'b0, 0, 1'b0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.res_valid && n < 100);
      chk("t3_res_valid_seen", 32'(bus.res_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_held_valid", 32'(bus.res_valid), 32'd1);
         chk("t3_held_data", bus.res_data, 32'd300);
         chk("t3_not_ready", 32'(bus.in_ready), 32'd0);
      end
      step();
      bus.res_ready = 1'b1;
      wait_result("t3_res", 300, 1'b1, 1'b0);
      vs = '{1, 1, 1, 1};
      send_frame(N, 1'b0, 0, 1'b0);
      wait_result("t3_ones", 10, 1'b1, 1'b0);

      // 4: flush mid-frame, sample presented with flush is dropped
      vs = '{10, 20, 30, 40};
      send_frame(2, 1'b0, 0, 1'b0);
      r0 = rst_pulses;
      bus.in_valid = 1'b1; bus.in_data = DW'(99); bus.flush = 1'b1;
      step();
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      step(); step();
      chk("t4_flush_pulses", rst_pulses - r0, 32'd1);
      send_frame(N, 1'b0, 0, 1'b0);
      wait_result("t4_res", 300, 1'b1, 1'b0);

      // 5: reset mid-frame clears coefficients
      send_frame(2, 1'b0, 0, 1'b0);
      reset = 1'b0;
      step();
      reset = 1'b1;
      step();
      send_frame(N, 1'b0, 0, 1'b0);
      wait_result("t5_zero_coef", 0, 1'b1, 1'b0);
      cs = '{1, 2, 3, 4};
      set_coefs();
      send_frame(N, 1'b0, 0, 1'b0);
      wait_result("t5_res", 300, 1'b1, 1'b0);

      // 6: extreme operands wrap to zero, with and without gaps
      cs = '{-32768, -32768, -32768, -32768};
      set_coefs();
      vs = '{-32768, -32768, -32768, -32768};
      l0 = load_cmds; a0 = add_cmds;
      send_frame(N, 1'b0, 0, 1'b0);
      wait_result("t6_wrap", 0, 1'b1, 1'b0);
      send_frame(N, 1'b0, 50, 1'b0);
      wait_result("t6_wrap_gaps", 0, 1'b1, 1'b0);
      chk("t6_cmds", (load_cmds - l0) + (add_cmds - a0), 32'd8);

      // randomized frames against the model
      for (int f = 0; f < 40; f++) begin
         if ($urandom_range(3) == 0) begin
            for (int i = 0; i < N; i++) cs[i] = int'($urandom_range(65535));
            set_coefs();
         end
         for (int i = 0; i < N; i++) vs[i] = int'($urandom_range(65535));
         send_frame(N, 1'($urandom_range(1)), 30, 1'b1);
         wait_result("rnd_res", 0, 1'b0, 1'b1);
      end
      bus.res_ready = 1'b1;
      repeat (4) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
